// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler: round-robin green/yellow/all-red sequencer for four approaches
module traffic_phase_scheduler #(
   parameter int GREEN_MIN = 4,
   parameter int GREEN_EXT = 8,
   parameter int YELLOW_T  = 2,
   parameter int ALLRED_T  = 1,
   parameter int CNT_W     = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   input  logic [3:0] heavy,
   output logic [1:0] current_state,
   output logic [1:0] active_dir,
   output logic [3:0] grant,
   output logic [1:0] NS_light,
   output logic [1:0] SN_light,
   output logic [1:0] EW_light,
   output logic [1:0] WE_light
);
   typedef enum logic [1:0] {IDLE, GREEN, YELLOW, ALLRED} state_t;
   localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] G_MIN = CNT_W'(GREEN_MIN);
   localparam logic [CNT_W-1:0] G_EXT = CNT_W'(GREEN_EXT);
   localparam logic [CNT_W-1:0] Y_T   = CNT_W'(YELLOW_T);
   localparam logic [CNT_W-1:0] A_T   = CNT_W'(ALLRED_T);
   state_t           state;
   logic [1:0]       ptr, win;
   logic [CNT_W-1:0] t;
   logic [7:0]       lt;
   // lowest offset from ptr wins, so the last holder is searched last
   always_comb begin
      win = ptr;
      for (int k = 3; k >= 0; k--)
         if (req[ptr + 2'(k) + 2'd1]) win = ptr + 2'(k) + 2'd1;
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         active_dir <= '0;
         grant      <= '0;
         lt         <= '0;
         t          <= '0;
         ptr        <= 2'd3;
      end else begin
         case (state)
            GREEN:
               if (t < G_MIN || (t < G_EXT && heavy[active_dir])) t <= t + 1'b1;
               else begin
                  state <= YELLOW;
                  ptr   <= active_dir;
                  t     <= ONE;
                  grant <= '0;
                  lt    <= 8'b01 << {active_dir, 1'b0};
               end
            YELLOW:
               if (t < Y_T) t <= t + 1'b1;
               else begin
                  state <= ALLRED;
                  t     <= ONE;
                  lt    <= '0;
               end
            IDLE, ALLRED:
               if (state == ALLRED && t < A_T) t <= t + 1'b1;
               else if (|req) begin
                  state      <= GREEN;
                  active_dir <= win;
                  t          <= ONE;
                  grant      <= 4'b1 << win;
                  lt         <= 8'b10 << {win, 1'b0};
               end else begin
                  state <= IDLE;
                  t     <= '0;
               end
         endcase
      end
   end
   assign current_state = state;
   assign NS_light = lt[1:0];
   assign SN_light = lt[3:2];
   assign EW_light = lt[5:4];
   assign WE_light = lt[7:6];
endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// tb_traffic_phase_scheduler: directed and random checks against a phase-level reference model
module tb_traffic_phase_scheduler;
   localparam int GMIN = 4, GEXT = 8, YT = 2, AT = 1;
   localparam int S_IDLE = 0, S_GREEN = 1, S_YELLOW = 2, S_ALLRED = 3;
   logic clk = 0, rst = 0;
   logic [3:0] req = 0, heavy = 0;
   logic [1:0] current_state, active_dir, NS_light, SN_light, EW_light, WE_light;
   logic [3:0] grant;
   int errors = 0, checks = 0;
   int m_state = S_IDLE, m_dir = 0, m_ptr = 3, m_len = 0;
   int run = 0, last_run = 0;
   logic [3:0] prev_grant = 0;
   logic [1:0] prev_state = 0;
   logic [3:0] gseq[$];

   traffic_phase_scheduler dut (
      .clk(clk), .rst(rst), .req(req), .heavy(heavy),
      .current_state(current_state), .active_dir(active_dir), .grant(grant),
      .NS_light(NS_light), .SN_light(SN_light), .EW_light(EW_light), .WE_light(WE_light)
   );

   always #5 clk = ~clk;

   function automatic int pick(input logic [3:0] r, input int p);
      for (int k = 1; k <= 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
      return -1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // advance the model one edge: phase length counts cycles spent in the current phase
   task automatic model_step();
      int w;
      if (!rst) begin
         m_state = S_IDLE; m_dir = 0; m_ptr = 3; m_len = 0;
      end else if (m_state == S_GREEN) begin
         if (m_len >= GMIN && (m_len >= GEXT || !heavy[m_dir])) begin
            m_state = S_YELLOW; m_ptr = m_dir; m_len = 1;
         end else m_len++;
      end else if (m_state == S_YELLOW) begin
         if (m_len >= YT) begin m_state = S_ALLRED; m_len = 1; end
         else m_len++;
      end else if (m_state == S_ALLRED && m_len < AT) m_len++;
      else begin
         w = pick(req, m_ptr);
         if (w >= 0) begin m_state = S_GREEN; m_dir = w; m_len = 1; end
         else begin m_state = S_IDLE; m_len = 0; end
      end
   endtask

   task automatic check_all();
      logic [7:0] exp_l, obs_l;
      logic [3:0] exp_g;
      int nonred;
      exp_g = (m_state == S_GREEN) ? 4'(1 << m_dir) : 4'd0;
      exp_l = 0;
      if (m_state == S_GREEN) exp_l[m_dir*2 +: 2] = 2'b10;
      if (m_state == S_YELLOW) exp_l[m_dir*2 +: 2] = 2'b01;
      obs_l = {WE_light, EW_light, SN_light, NS_light};
      chk("model", {16'd0, current_state, active_dir, grant, obs_l},
          {16'd0, 2'(m_state), 2'(m_dir), exp_g, exp_l});
      nonred = 0;
      for (int i = 0; i < 4; i++) begin
         if (obs_l[i*2 +: 2] != 2'b00) nonred++;
         chk("no_11", 32'(obs_l[i*2 +: 2] == 2'b11), 0);
      end
      chk("one_light", 32'(nonred <= 1), 1);
      chk("grant_onehot0", 32'($onehot0(grant)), 1);
      chk("grant_iff_green", 32'((grant != 0) == (current_state == 2'd1)), 1);
      chk("green_after_green_or_yellow",
          32'(grant != 0 && ((prev_grant != 0 && prev_grant != grant) || prev_state == 2'd2)), 0);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check_all();
      if (grant != 0 && prev_grant == 0) gseq.push_back(grant);
      if (grant != 0) run++;
      else if (run != 0) begin last_run = run; run = 0; end
      prev_grant = grant;
      prev_state = current_state;
   endtask

   task automatic do_reset();
      rst = 0;
      tick();
      rst = 1;
      run = 0;
      gseq.delete();
   endtask

   initial begin
      int n;
      logic [3:0] exp_seq[5];
      // 1: reset with everyone requesting, then NS first
      rst = 0; req = 4'b1111; heavy = 0;
      tick(); tick();
      chk("rst_lights", {NS_light, SN_light, EW_light, WE_light}, 0);
      chk("rst_grant", grant, 0);
      chk("rst_state", current_state, 0);
      rst = 1;
      tick();
      chk("first_ns_green", NS_light, 2'b10);
      chk("first_grant", grant, 4'b0001);
      // 2: NS alone, no congestion
      do_reset();
      req = 4'b0001;
      for (int i = 0; i < 21; i++) tick();
      chk("green_min_len", last_run, GMIN);
      // 3: NS congested, capped
      heavy = 4'b0001;
      for (int i = 0; i < 20; i++) tick();
      chk("green_cap_len", last_run, GEXT);
      // 4: round robin
      do_reset();
      req = 4'b1111; heavy = 0;
      for (int i = 0; i < 30; i++) tick();
      exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      chk("rr_count", 32'(gseq.size() >= 5), 1);
      for (int i = 0; i < 5 && i < gseq.size(); i++) chk("rr_seq", gseq[i], exp_seq[i]);
      chk("rr_len", last_run, GMIN);
      // 5: EW extension ended by heavy dropping on green cycle 6
      do_reset();
      req = 4'b0100; heavy = 4'b0100;
      n = 0;
      while (run < 6 && n < 30) begin tick(); n++; end
      chk("ew_reach6", run, 6);
      heavy = 0;
      tick();
      chk("ew_yellow", current_state, 2'd2);
      chk("ew_len", last_run, 6);
      chk("ew_yellow_light", EW_light, 2'b01);
      // 6: reset during SN green
      do_reset();
      req = 4'b0010;
      n = 0;
      while (run < 3 && n < 20) begin tick(); n++; end
      chk("sn_reach3", {grant, 28'(run)}, {4'b0010, 28'd3});
      rst = 0; req = 4'b1111;
      tick();
      chk("midgreen_rst_lights", {NS_light, SN_light, EW_light, WE_light}, 0);
      chk("midgreen_rst_grant", grant, 0);
      rst = 1;
      tick();
      chk("after_rst_ns", grant, 4'b0001);
      // 7: requests vanish during yellow
      do_reset();
      req = 4'b0001;
      n = 0;
      while (current_state != 2'd2 && n < 20) begin tick(); n++; end
      chk("reach_yellow", current_state, 2'd2);
      req = 0;
      tick(); tick(); tick();
      chk("back_idle", current_state, 2'd0);
      chk("idle_lights", {NS_light, SN_light, EW_light, WE_light}, 0);
      req = 4'b1000;
      tick();
      chk("we_green", WE_light, 2'b10);
      chk("we_grant", grant, 4'b1000);
      // random traffic with occasional resets
      for (int i = 0; i < 400; i++) begin
         rst = ($urandom_range(0, 59) != 0);
         req = 4'($urandom) & 4'($urandom);
         heavy = 4'($urandom);
         tick();
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1);
   end
endmodule

// File: doc/traffic_phase_scheduler.md
Name: traffic_phase_scheduler

Overview:
- Sequences right-of-way among the four approaches NS, SN, EW, WE of the adaptive traffic light controller.
- Grants green to one approach at a time, using round-robin arbitration over the per-approach presence sensors (S1).
- Green is extended while the granted approach's congestion sensor (S5) is high, up to a hard cap that prevents starvation.
- Green is always followed by yellow, then all-red, before the next grant.

Parameters:
- GREEN_MIN, 4: minimum green length in cycles (≥1).
- GREEN_EXT, 8: maximum green length in cycles when congested (≥ GREEN_MIN).
- YELLOW_T, 2: yellow length in cycles (≥1).
- ALLRED_T, 1: all-red clearance length in cycles (≥1).
- CNT_W, 4: phase timer width; must hold max(GREEN_EXT, YELLOW_T, ALLRED_T).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- req  in  4  S1 presence per approach, level-sensitive; bit0=NS, bit1=SN, bit2=EW, bit3=WE.
- heavy  in  4  S5 congestion per approach, same bit order as req.
- current_state  out  2  FSM state: 0=IDLE, 1=GREEN, 2=YELLOW, 3=ALLRED.
- active_dir  out  2  index of the approach currently or last granted.
- grant  out  4  one-hot, high while active_dir is green.
- NS_light, SN_light, EW_light, WE_light  out  2 each  light encoding: 00=red, 01=yellow, 10=green; 11 is never driven.

Behaviour:
- Reset (rst=0 at an edge), values after that edge:
  - current_state=IDLE, active_dir=0, grant=0, all lights 00, timer=0.
  - Round-robin pointer ptr=3, so index 0 has first priority.
  - Reset takes priority over every other event, including mid-GREEN and mid-YELLOW.
- Arbitration (combinational on the sampled req):
  - Search indices ptr+1, ptr+2, ptr+3, ptr+4 (mod 4); the first with req=1 wins.
  - The previous holder is therefore lowest priority, but still wins if it is the only requester.
  - Arbitration is evaluated only in IDLE, and on the last ALLRED cycle.
- IDLE:
  - All lights red.
  - req==0: stay in IDLE.
  - Otherwise: active_dir←winner, go to GREEN, timer←1. The green light is visible after the same edge that sampled req (1-cycle latency).
- GREEN:
  - Only lights[active_dir]=10, grant[active_dir]=1; all other lights red.
  - Timer t counts green cycles, starting at 1.
  - t < GREEN_MIN: stay in GREEN, t←t+1.
  - GREEN_MIN ≤ t < GREEN_EXT and heavy[active_dir]=1: stay in GREEN, t←t+1.
  - GREEN_MIN ≤ t < GREEN_EXT and heavy[active_dir]=0: go to YELLOW.
  - t == GREEN_EXT: go to YELLOW unconditionally.
  - Green length is therefore always within [GREEN_MIN, GREEN_EXT].
  - Loss of req[active_dir] during green does not shorten it below GREEN_MIN.
  - On the GREEN→YELLOW transition: ptr←active_dir, t←1.
- YELLOW:
  - lights[active_dir]=01, grant=0.
  - After YELLOW_T cycles: go to ALLRED, t←1.
- ALLRED:
  - All lights red.
  - After ALLRED_T cycles, arbitrate on the last ALLRED cycle:
    - winner found: go to GREEN, active_dir←winner.
    - req==0: go to IDLE.
- Invariants, checked every cycle:
  - At most one light is non-red.
  - grant is one-hot or zero.
  - grant≠0 exactly when current_state=GREEN.
  - No green ever directly follows another green or a yellow.
- Timer behaviour:
  - The timer saturates; it never wraps.
  - GREEN_EXT == GREEN_MIN disables extension.
- heavy bits of non-granted approaches are ignored.
- Sensors are assumed synchronous to clk; no metastability handling is provided.

Test Plan:
1. rst=0 for 2 edges with req=1111 → lights all 00, grant=0, state IDLE. First edge after rst=1 → NS_light=10, grant=0001.
2. req=0001, heavy=0 → NS green 4 cycles, yellow 2, red 1, then green again; 7-cycle period repeats.
3. req=0001, heavy=0001 held → NS green exactly 8 cycles, then yellow despite heavy still high.
4. req=1111, heavy=0 → grant sequence 0001, 0010, 0100, 1000, 0001. Each green 4 cycles, separated by 3 non-green cycles.
5. req=0100, heavy=0100, heavy dropped on green cycle 6 → EW yellow starts at cycle 7; green lasted 6 cycles.
6. rst=0 asserted at green cycle 3 of SN, with req=1111 → all red next edge. After release, NS (index 0) is granted first.
7. req dropped to 0000 during YELLOW → ALLRED, then IDLE with all lights red. Next req=1000 → WE green 1 cycle later.
